pin_wiggler_gen: RTL and testbench

Parametrised successor to the 16-bit free-running Pmod pin counter.
- Drives WIDTH output pins from a pattern generator.
- Patterns: binary up, binary down, Gray code, walking-one.
- Pattern steps at a rate set by a programmable prescaler.
- Emits tick and wrap strobes; drives a status LED that toggles on each wrap.

---
 rtl/pin_wiggler_pkg.sv | 16 +
 rtl/wiggler_prescaler.sv | 40 ++++
 rtl/pin_wiggler_gen.sv | 141 ++++++++++++++
 tb/tb_pin_wiggler_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pin_wiggler_pkg.sv
// Shared mode encodings and sequencing phase type for the pin wiggler generator.
package pin_wiggler_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BIN_UP   = 2'd0;
  localparam mode_t MODE_BIN_DOWN = 2'd1;
  localparam mode_t MODE_GRAY     = 2'd2;
  localparam mode_t MODE_WALK     = 2'd3;

  typedef enum logic {
    PH_RUN    = 1'b0,
    PH_REINIT = 1'b1
  } phase_e;

endpackage

// File: rtl/wiggler_prescaler.sv
// Step-rate prescaler: a step fires every prescale+1 enabled cycles.
// The >= compare lets a shrinking prescale take effect without a stall.
module wiggler_prescaler
  import pin_wiggler_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clear,
  output logic                  step
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  hit;

  always_comb begin
    hit       = (pre_cnt_q >= prescale);
    step      = enable & hit;
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (enable) begin
      pre_cnt_d = hit ? '0 : pre_cnt_q + PRE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pin_wiggler_gen.sv
// Parametrised pin pattern generator (binary up/down, Gray, walking-one) with prescaled stepping.
// Optional macro WIGGLER_PRESET_EN adds load_valid/load_value for presetting the count.
//
// phase     | meaning
// PH_RUN    | normal operation, mode_ready=1, steps allowed
// PH_REINIT | cycle after a mode acceptance, mode_ready=0, no step
module pin_wiggler_gen
  import pin_wiggler_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            mode,
  input  logic                  mode_valid,
  output logic                  mode_ready,
  output logic [WIDTH-1:0]      pins,
  output logic                  tick,
  output logic                  wrap,
  output logic                  led
`ifdef WIGGLER_PRESET_EN
  ,
  input  logic                  load_valid,
  input  logic [WIDTH-1:0]      load_value
`endif
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  phase_e           phase_q, phase_d;
  mode_t            cur_mode_q, cur_mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pins_q, pins_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             led_q, led_d;
  logic             mode_ready_q, mode_ready_d;

  logic             accept, reinit, load_req, do_load, do_step, clear, step;
  logic [WIDTH-1:0] load_cnt;
  logic [WIDTH-1:0] step_cnt;
  logic             step_wraps;

  function automatic logic [WIDTH-1:0] pattern_of(input mode_t m, input logic [WIDTH-1:0] c);
    return (m == MODE_GRAY) ? (c ^ (c >> 1)) : c;
  endfunction

`ifdef WIGGLER_PRESET_EN
  assign load_req = load_valid;
  assign load_cnt = load_value;
`else
  assign load_req = 1'b0;
  assign load_cnt = '0;
`endif

  assign accept  = mode_valid & mode_ready_q;
  assign reinit  = (phase_q == PH_REINIT);
  assign do_load = load_req & ~accept;
  assign do_step = step & ~accept & ~reinit & ~do_load;
  assign clear   = accept | reinit | do_load;

  wiggler_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .prescale (prescale),
    .clear    (clear),
    .step     (step)
  );

  always_comb begin
    step_cnt   = cnt_q + ONE;
    step_wraps = &cnt_q;
    case (cur_mode_q)
      MODE_BIN_DOWN: begin
        step_cnt   = cnt_q - ONE;
        step_wraps = (cnt_q == '0);
      end
      MODE_WALK: begin
        step_cnt   = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
        step_wraps = cnt_q[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    phase_d      = PH_RUN;
    mode_ready_d = 1'b1;
    cur_mode_d   = cur_mode_q;
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    wrap_d       = 1'b0;
    if (accept) begin
      phase_d      = PH_REINIT;
      mode_ready_d = 1'b0;
      cur_mode_d   = mode;
      cnt_d        = (mode == MODE_WALK) ? ONE : '0;
    end else if (do_load) begin
      cnt_d = load_cnt;
    end else if (do_step) begin
      cnt_d  = step_cnt;
      tick_d = 1'b1;
      wrap_d = step_wraps;
    end
    pins_d = pattern_of(cur_mode_d, cnt_d);
    led_d  = led_q ^ wrap_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PH_RUN;
      cur_mode_q   <= MODE_BIN_UP;
      cnt_q        <= '0;
      pins_q       <= '0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
      led_q        <= 1'b0;
      mode_ready_q <= 1'b1;
    end else begin
      phase_q      <= phase_d;
      cur_mode_q   <= cur_mode_d;
      cnt_q        <= cnt_d;
      pins_q       <= pins_d;
      tick_q       <= tick_d;
      wrap_q       <= wrap_d;
      led_q        <= led_d;
      mode_ready_q <= mode_ready_d;
    end
  end

  assign mode_ready = mode_ready_q;
  assign pins       = pins_q;
  assign tick       = tick_q;
  assign wrap       = wrap_q;
  assign led        = led_q;

endmodule

// File: tb/tb_pin_wiggler_gen.sv
// Directed vector bench for pin_wiggler_gen at WIDTH=4; preset checks run when WIGGLER_PRESET_EN is defined.
module tb_pin_wiggler_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] prescale;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_ready;
  logic [3:0] pins;
  logic       tick;
  logic       wrap;
  logic       led;
  logic       load_valid;
  logic [3:0] load_value;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pin_wiggler_gen #(.WIDTH(4), .PRESCALE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .prescale   (prescale),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .pins       (pins),
    .tick       (tick),
    .wrap       (wrap),
    .led        (led)
`ifdef WIGGLER_PRESET_EN
    ,
    .load_valid (load_valid),
    .load_value (load_value)
`endif
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [7:0] ps;
    logic [1:0] md;
    logic       mv;
    logic       lv;
    logic [3:0] lval;
    logic [3:0] e_pins;
    logic       e_tick;
    logic       e_wrap;
    logic       e_led;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rst, input logic en, input logic [7:0] ps,
                              input logic [1:0] md, input logic mv, input logic lv, input logic [3:0] lval,
                              input logic [3:0] e_pins, input logic e_tick, input logic e_wrap,
                              input logic e_led, input logic e_rdy);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en; v.ps = ps; v.md = md; v.mv = mv;
    v.lv = lv; v.lval = lval; v.e_pins = e_pins; v.e_tick = e_tick;
    v.e_wrap = e_wrap; v.e_led = e_led; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input string sig, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s got=%0h want=%0h", name, sig, got, want);
    end
  endtask

  task automatic run(input vec_t v);
    reset      = v.rst;
    enable     = v.en;
    prescale   = v.ps;
    mode       = v.md;
    mode_valid = v.mv;
    load_valid = v.lv;
    load_value = v.lval;
    @(posedge clk);
    #1;
    chk(v.name, "pins",  pins,               v.e_pins);
    chk(v.name, "tick",  {3'b0, tick},       {3'b0, v.e_tick});
    chk(v.name, "wrap",  {3'b0, wrap},       {3'b0, v.e_wrap});
    chk(v.name, "led",   {3'b0, led},        {3'b0, v.e_led});
    chk(v.name, "ready", {3'b0, mode_ready}, {3'b0, v.e_rdy});
  endtask

  logic [3:0] gray_tab [16];
  logic [3:0] ps2_pins [6];
  logic       ps2_tick [6];

  initial begin
    gray_tab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    ps2_pins = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h2};
    ps2_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; enable = 1'b0; prescale = '0; mode = '0;
    mode_valid = 1'b0; load_valid = 1'b0; load_value = '0;

    // reset, BIN_UP full cycle, prescaler rate and mid-count prescale decrease
    vecs.push_back(mk("reset", 1, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk("bin_up", 0, 1, 0, 0, 0, 0, 0, 4'((i + 1) % 16), 1, i == 15, i == 15, 1));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk("ps2", 0, 1, 2, 0, 0, 0, 0, ps2_pins[i], ps2_tick[i], 0, 1, 1));
    vecs.push_back(mk("ps2_hold", 0, 1, 2, 0, 0, 0, 0, 4'h2, 0, 0, 1, 1));
    vecs.push_back(mk("ps2_hold", 0, 1, 2, 0, 0, 0, 0, 4'h2, 0, 0, 1, 1));
    vecs.push_back(mk("ps_drop", 0, 1, 0, 0, 0, 0, 0, 4'h3, 1, 0, 1, 1));
    vecs.push_back(mk("ps_drop2", 0, 1, 0, 0, 0, 0, 0, 4'h4, 1, 0, 1, 1));
    foreach (vecs[i]) run(vecs[i]);

    // GRAY accepted over a step; request during reinit must be ignored
    run(mk("gray_acc", 0, 1, 0, 2, 1, 0, 0, 4'h0, 0, 0, 1, 0));
    run(mk("gray_reinit", 0, 1, 0, 3, 1, 0, 0, 4'h0, 0, 0, 1, 1));
    for (int i = 0; i < 16; i++)
      run(mk("gray", 0, 1, 0, 2, 0, 0, 0, gray_tab[i], 1, i == 15, i != 15, 1));

    // WALK rotation, wrap, and enable freeze
    run(mk("walk_acc", 0, 1, 0, 3, 1, 0, 0, 4'h1, 0, 0, 0, 0));
    run(mk("walk_reinit", 0, 1, 0, 3, 0, 0, 0, 4'h1, 0, 0, 0, 1));
    run(mk("walk", 0, 1, 0, 3, 0, 0, 0, 4'h2, 1, 0, 0, 1));
    run(mk("walk", 0, 1, 0, 3, 0, 0, 0, 4'h4, 1, 0, 0, 1));
    run(mk("walk", 0, 1, 0, 3, 0, 0, 0, 4'h8, 1, 0, 0, 1));
    run(mk("walk_wrap", 0, 1, 0, 3, 0, 0, 0, 4'h1, 1, 1, 1, 1));
    for (int i = 0; i < 5; i++)
      run(mk("walk_frozen", 0, 0, 0, 3, 0, 0, 0, 4'h1, 0, 0, 1, 1));
    run(mk("walk_resume", 0, 1, 0, 3, 0, 0, 0, 4'h2, 1, 0, 1, 1));

    // BIN_DOWN: first step wraps 0->F, then a full pass to the next wrap
    run(mk("down_acc", 0, 1, 0, 1, 1, 0, 0, 4'h0, 0, 0, 1, 0));
    run(mk("down_reinit", 0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0, 1, 1));
    run(mk("down_wrap0", 0, 1, 0, 1, 0, 0, 0, 4'hF, 1, 1, 0, 1));
    for (int i = 1; i < 16; i++)
      run(mk("down", 0, 1, 0, 1, 0, 0, 0, 4'(15 - i), 1, 0, 0, 1));
    run(mk("down_wrap1", 0, 1, 0, 1, 0, 0, 0, 4'hF, 1, 1, 1, 1));

    // same-mode re-request reinitialises; reset lands in the reinit cycle
    run(mk("down_rereq", 0, 1, 0, 1, 1, 0, 0, 4'h0, 0, 0, 1, 0));
    run(mk("reset_reinit", 1, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 1));
    run(mk("post_reset_up", 0, 1, 0, 1, 0, 0, 0, 4'h1, 1, 0, 0, 1));

    // mode request accepted while disabled
    run(mk("acc_disabled", 0, 0, 0, 3, 1, 0, 0, 4'h1, 0, 0, 0, 0));
    run(mk("reinit_disabled", 0, 0, 0, 3, 0, 0, 0, 4'h1, 0, 0, 0, 1));
    run(mk("walk_after", 0, 1, 0, 3, 0, 0, 0, 4'h2, 1, 0, 0, 1));

`ifdef WIGGLER_PRESET_EN
    run(mk("pre_reset", 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1));
    run(mk("load_e", 0, 1, 0, 0, 0, 1, 4'hE, 4'hE, 0, 0, 0, 1));
    run(mk("load_step_f", 0, 1, 0, 0, 0, 0, 0, 4'hF, 1, 0, 0, 1));
    run(mk("load_wrap", 0, 1, 0, 0, 0, 0, 0, 4'h0, 1, 1, 1, 1));
    run(mk("mode_over_load", 0, 1, 0, 3, 1, 1, 4'h5, 4'h1, 0, 0, 1, 0));
    run(mk("mode_over_load_ri", 0, 1, 0, 3, 0, 0, 0, 4'h1, 0, 0, 1, 1));
    run(mk("walk_from_acc", 0, 1, 0, 3, 0, 0, 0, 4'h2, 1, 0, 1, 1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
